draw_grid_background: RTL and testbench

//  Parametrised successor of the fixed background generator: VGA pipeline stage fed by the timing

---
 rtl/draw_grid_background.sv | 197 +++++++++++++++++++
 tb/tb_draw_grid_background.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/draw_grid_background.sv
// draw_grid_background: paints the frame border, channel columns, horizontal division
// lines and an optional blinking column highlight behind the overlay stages. Timing
// and colour leave two pixel clocks after they arrive. Colour/selection updates are
// taken through a one-word valid/ready slot and only become active at a frame boundary.
module draw_grid_background #(
   parameter int          H_ACTIVE    = 1024,
   parameter int          V_ACTIVE    = 768,
   parameter int          CH_NUM      = 13,
   parameter int          DIV_SPACING = 64,
   parameter int          BLINK_LOG2  = 4,
   parameter logic [11:0] BG_RST      = 12'h888,
   parameter logic [11:0] GRID_RST    = 12'hfff,
   parameter logic [11:0] SEL_COLOR   = 12'h44f
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [11:0] vcount_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic [11:0] hcount_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [11:0] cfg_bg,
   input  logic [11:0] cfg_grid,
   input  logic [4:0]  cfg_sel_ch,
   input  logic        cfg_sel_en,
   output logic [11:0] vcount_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic [11:0] hcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic [11:0] rgb_out,
   output logic [7:0]  frame_cnt
);

   localparam int          CH_W     = H_ACTIVE / CH_NUM;
   // Index value used for pixels right of the last column (no column).
   localparam logic [5:0]  IDX_NONE = 6'(CH_NUM);
   localparam logic [11:0] OFF_LAST = 12'(CH_W - 1);
   localparam logic [11:0] ROW_LAST = 12'(DIV_SPACING - 1);
   localparam logic [11:0] V_LAST   = 12'(V_ACTIVE - 1);
   localparam logic [11:0] H_LAST   = 12'(H_ACTIVE - 1);

   // Column / row tracking (state for the previous pixel and the value for this one)
   logic [5:0]  col_idx_q, col_idx_c;
   logic [11:0] col_off_q, col_off_c;
   logic [11:0] row_q, row_c;

   // Stage 1 registers
   logic        blank_p1, top_p1, bot_p1, left_p1, right_p1, grid_p1;
   logic [5:0]  idx_p1;
   logic [11:0] vcount_p1, hcount_p1;
   logic        vsync_p1, vblnk_p1, hsync_p1, hblnk_p1;

   // Configuration: active copy and pending slot
   logic [11:0] bg_act, grid_act, bg_pend, grid_pend;
   logic [4:0]  sel_ch_act, sel_ch_pend;
   logic        sel_en_act, sel_en_pend;
   logic        vblnk_prev;
   logic        frame_edge;
   logic        sel_hit;

   assign frame_edge = vblnk_in & ~vblnk_prev;

   function automatic logic [11:0] pick_color(
      input logic        blank, top, bot, left, right, grid, hit,
      input logic [11:0] bg, grid_c
   );
      if (blank)      return 12'h000;
      else if (top)   return 12'hff0;
      else if (bot)   return 12'hf00;
      else if (left)  return 12'h0f0;
      else if (right) return 12'h00f;
      else if (grid)  return grid_c;
      else if (hit)   return SEL_COLOR;
      else            return bg;
   endfunction

   // Next column index/offset: restart at line start, step offset, roll into next column
   always_comb begin
      col_idx_c = col_idx_q;
      col_off_c = col_off_q + 12'd1;
      if (hcount_in == 12'd0) begin
         col_idx_c = 6'd0;
         col_off_c = 12'd0;
      end else if (col_idx_q == IDX_NONE) begin
         // past the last column: hold a non-zero offset so no further edges appear
         col_off_c = 12'd1;
      end else if (col_off_q == OFF_LAST) begin
         col_idx_c = col_idx_q + 6'd1;
         col_off_c = 12'd0;
      end
   end

   // Next row phase: zero on the first line, advance once per line start
   always_comb begin
      row_c = row_q;
      if (hcount_in == 12'd0) begin
         if (vcount_in == 12'd0)   row_c = 12'd0;
         else if (row_q == ROW_LAST) row_c = 12'd0;
         else                      row_c = row_q + 12'd1;
      end
   end

   // Highlight decision for the pixel held in stage 1
   always_comb begin
      sel_hit = sel_en_act && (idx_p1 < IDX_NONE) && (idx_p1 == {1'b0, sel_ch_act})
                && frame_cnt[BLINK_LOG2];
   end

   // Column/row tracking state follows the pixel stream
   always_ff @(posedge pclk) begin
      col_idx_q <= col_idx_c;
      col_off_q <= col_off_c;
      row_q     <= row_c;
   end

   // ---- stage 1: geometry flags, column index, timing ----
   always_ff @(posedge pclk) begin
      blank_p1  <= vblnk_in | hblnk_in;
      top_p1    <= (vcount_in == 12'd0);
      bot_p1    <= (vcount_in == V_LAST);
      left_p1   <= (hcount_in == 12'd0);
      right_p1  <= (hcount_in == H_LAST);
      grid_p1   <= ((col_off_c == 12'd0) && (col_idx_c != 6'd0)) || (row_c == 12'd0);
      idx_p1    <= col_idx_c;
      vcount_p1 <= vcount_in;
      vsync_p1  <= vsync_in;
      vblnk_p1  <= vblnk_in;
      hcount_p1 <= hcount_in;
      hsync_p1  <= hsync_in;
      hblnk_p1  <= hblnk_in;
   end

   // ---- stage 2: colour and delayed timing to the outputs ----
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         vcount_out <= 12'd0;
         vsync_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         hcount_out <= 12'd0;
         hsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         rgb_out    <= 12'h000;
      end else begin
         vcount_out <= vcount_p1;
         vsync_out  <= vsync_p1;
         vblnk_out  <= vblnk_p1;
         hcount_out <= hcount_p1;
         hsync_out  <= hsync_p1;
         hblnk_out  <= hblnk_p1;
         rgb_out    <= pick_color(blank_p1, top_p1, bot_p1, left_p1, right_p1, grid_p1,
                                  sel_hit, bg_act, grid_act);
      end
   end

   // Pending slot contents: captured on an accepted transfer
   always_ff @(posedge pclk) begin
      if (cfg_valid && cfg_ready) begin
         bg_pend     <= cfg_bg;
         grid_pend   <= cfg_grid;
         sel_ch_pend <= cfg_sel_ch;
         sel_en_pend <= cfg_sel_en;
      end
   end

   // Frame counter, handshake and frame-boundary config swap
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         vblnk_prev <= 1'b0;
         frame_cnt  <= 8'd0;
         cfg_ready  <= 1'b1;
         bg_act     <= BG_RST;
         grid_act   <= GRID_RST;
         sel_ch_act <= 5'd0;
         sel_en_act <= 1'b0;
      end else begin
         vblnk_prev <= vblnk_in;
         if (frame_edge) frame_cnt <= frame_cnt + 8'd1;
         // a word accepted on the boundary cycle itself is only in the slot afterwards,
         // so it naturally waits for the following boundary
         if (frame_edge && !cfg_ready) begin
            bg_act     <= bg_pend;
            grid_act   <= grid_pend;
            sel_ch_act <= sel_ch_pend;
            sel_en_act <= sel_en_pend;
            cfg_ready  <= 1'b1;
         end else if (cfg_valid && cfg_ready) begin
            cfg_ready  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_draw_grid_background.sv
// Bench for draw_grid_background: drives compressed frames (only probed lines are
// swept pixel by pixel), pushes hand-computed expectations into a scoreboard and a
// negedge monitor compares them when the pixel reaches the outputs.
module tb_draw_grid_background;

   logic        pclk = 1'b0;
   logic        rst;
   logic [11:0] vcount_in, hcount_in;
   logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
   logic        cfg_valid, cfg_ready, cfg_sel_en;
   logic [11:0] cfg_bg, cfg_grid;
   logic [4:0]  cfg_sel_ch;
   logic [11:0] vcount_out, hcount_out, rgb_out;
   logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
   logic [7:0]  frame_cnt;

   draw_grid_background dut (
      .pclk(pclk), .rst(rst),
      .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
      .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bg(cfg_bg), .cfg_grid(cfg_grid),
      .cfg_sel_ch(cfg_sel_ch), .cfg_sel_en(cfg_sel_en),
      .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
      .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
      .rgb_out(rgb_out), .frame_cnt(frame_cnt)
   );

   always #5 pclk = ~pclk;

   int unsigned cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int unsigned stamp;
      logic [11:0] v, h;
      logic        vs, vb, hs, hb;
      logic [11:0] rgb;
      logic [7:0]  fc;
   } exp_t;
   typedef struct { int tag; int v; int h; logic [11:0] rgb; } probe_t;
   typedef struct { int tag; int v; logic [11:0] bg, grid; logic [4:0] ch; logic en; } cfg_t;

   exp_t   sb[$];
   probe_t probes[$];
   cfg_t   cfgs[$];
   exp_t   mon_e;
   logic [7:0] fc_model = 8'd0;
   logic       vb_prev_drv = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add_p(input int tag, input int v, input int h, input logic [11:0] rgb);
      probe_t p;
      p.tag = tag; p.v = v; p.h = h; p.rgb = rgb;
      probes.push_back(p);
   endtask

   task automatic add_c(input int tag, input int v, input logic [11:0] bg, input logic [11:0] grid,
                        input logic [4:0] ch, input logic en);
      cfg_t c;
      c.tag = tag; c.v = v; c.bg = bg; c.grid = grid; c.ch = ch; c.en = en;
      cfgs.push_back(c);
   endtask

   function automatic bit line_swept(input int tag, input int v);
      foreach (probes[i]) if (probes[i].tag == tag && probes[i].v == v) return 1'b1;
      return 1'b0;
   endfunction

   // Monitor: compare every expectation when its pixel reaches the outputs
   always @(negedge pclk) begin
      while (sb.size() > 0 && sb[0].stamp == cyc) begin
         mon_e = sb.pop_front();
         chk($sformatf("rgb v%0d h%0d", mon_e.v, mon_e.h), 32'(rgb_out), 32'(mon_e.rgb));
         chk($sformatf("timing v%0d h%0d", mon_e.v, mon_e.h),
             32'({vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out}),
             32'({mon_e.v, mon_e.h, mon_e.vs, mon_e.vb, mon_e.hs, mon_e.hb}));
         chk($sformatf("frame_cnt v%0d h%0d", mon_e.v, mon_e.h), 32'(frame_cnt), 32'(mon_e.fc));
      end
   end

   // Drive one pixel; apply config hooks, handshake checks and push probe expectations
   task automatic drive_px(input int tag, input int v, input int h, input logic vb);
      exp_t e;
      @(posedge pclk); #1;
      vcount_in = 12'(v);
      hcount_in = 12'(h);
      vblnk_in  = vb;
      hblnk_in  = (tag == 0 && v == 10 && h == 300);
      hsync_in  = (tag == 0 && v == 5 && h == 5);
      vsync_in  = (v == 769);
      cfg_valid = 1'b0;
      if (h == 0) begin
         foreach (cfgs[i]) if (cfgs[i].tag == tag && cfgs[i].v == v) begin
            cfg_valid  = 1'b1;
            cfg_bg     = cfgs[i].bg;
            cfg_grid   = cfgs[i].grid;
            cfg_sel_ch = cfgs[i].ch;
            cfg_sel_en = cfgs[i].en;
         end
         if (tag == 1 && v == 300) chk("ready before transfer", 32'(cfg_ready), 32'd1);
         if (tag == 1 && v == 350) chk("ready while pending", 32'(cfg_ready), 32'd0);
         if (tag == 1 && v == 768) chk("ready on boundary cycle", 32'(cfg_ready), 32'd0);
         if (tag == 1 && v == 769) chk("ready boundary+1", 32'(cfg_ready), 32'd1);
         if (tag == 2 && v == 768) chk("ready boundary xfer", 32'(cfg_ready), 32'd1);
         if (tag == 2 && v == 769) chk("ready held over boundary", 32'(cfg_ready), 32'd0);
         if (tag == 3 && v == 769) chk("ready after late apply", 32'(cfg_ready), 32'd1);
      end
      if (tag == 7 && v == 200 && h == 5) chk("ready pending before rst", 32'(cfg_ready), 32'd0);
      if (vb && !vb_prev_drv) fc_model = fc_model + 8'd1;
      vb_prev_drv = vb;
      foreach (probes[i]) if (probes[i].tag == tag && probes[i].v == v && probes[i].h == h) begin
         e.stamp = cyc + 2;
         e.v = vcount_in; e.h = hcount_in;
         e.vs = vsync_in; e.vb = vblnk_in; e.hs = hsync_in; e.hb = hblnk_in;
         e.rgb = probes[i].rgb;
         e.fc = fc_model;
         sb.push_back(e);
      end
   endtask

   task automatic run_frame(input int tag);
      for (int v = 0; v < 771; v++) begin
         int hmax;
         hmax = line_swept(tag, v) ? 1023 : 0;
         for (int h = 0; h <= hmax; h++) drive_px(tag, v, h, (v >= 768));
      end
   endtask

   task automatic fast_frame();
      drive_px(-1, 0, 0, 1'b0);
      drive_px(-1, 768, 0, 1'b1);
      drive_px(-1, 768, 1, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      vcount_in = '0; hcount_in = '0; vsync_in = 0; vblnk_in = 0; hsync_in = 0; hblnk_in = 0;
      cfg_valid = 0; cfg_bg = '0; cfg_grid = '0; cfg_sel_ch = '0; cfg_sel_en = 0;

      // frame 0: reset config, borders, grid, latency
      add_p(0, 0, 0, 12'hff0);    add_p(0, 0, 500, 12'hff0);
      add_p(0, 1, 100, 12'h888);  add_p(0, 100, 1, 12'h888);
      add_p(0, 5, 4, 12'h888);    add_p(0, 5, 5, 12'h888);   add_p(0, 5, 6, 12'h888);
      add_p(0, 10, 77, 12'h888);  add_p(0, 10, 78, 12'hfff); add_p(0, 10, 79, 12'h888);
      add_p(0, 10, 300, 12'h000); add_p(0, 10, 1015, 12'h888); add_p(0, 10, 1023, 12'h00f);
      add_p(0, 64, 0, 12'h0f0);   add_p(0, 64, 200, 12'hfff);
      add_p(0, 300, 1023, 12'h00f);
      add_p(0, 767, 500, 12'hf00); add_p(0, 767, 0, 12'hf00);
      add_p(0, 768, 5, 12'h000);  add_p(0, 769, 0, 12'h000);
      // frame 1: mid-frame config must not show; second word ignored
      add_c(1, 300, 12'h123, 12'hfff, 5'd0, 1'b0);
      add_c(1, 301, 12'h0ab, 12'hfff, 5'd0, 1'b0);
      add_p(1, 400, 100, 12'h888);
      // frame 2: first word active; new word offered on the boundary cycle
      add_p(2, 100, 100, 12'h123);
      add_c(2, 768, 12'h456, 12'h0ff, 5'd3, 1'b1);
      // frame 3: boundary-cycle word not yet active
      add_p(3, 100, 100, 12'h123); add_p(3, 64, 200, 12'hfff); add_p(3, 100, 250, 12'h123);
      // frame 4 (frame_cnt 4, blink off)
      add_p(4, 100, 250, 12'h456); add_p(4, 10, 78, 12'h0ff);
      add_p(4, 64, 250, 12'h0ff);  add_p(4, 100, 100, 12'h456);
      // frame_cnt 16: blink on, column 3 spans 234..311
      add_p(5, 100, 250, 12'h44f); add_p(5, 100, 233, 12'h456); add_p(5, 100, 234, 12'h0ff);
      add_p(5, 100, 311, 12'h44f); add_p(5, 100, 312, 12'h0ff); add_p(5, 100, 1015, 12'h456);
      add_p(5, 100, 0, 12'h0f0);
      add_c(5, 500, 12'h456, 12'h0ff, 5'd20, 1'b1);
      // frame_cnt 17: out-of-range selection highlights nothing
      add_p(6, 100, 250, 12'h456);
      // reset mid-line with a pending word
      add_c(7, 200, 12'habc, 12'h00f, 5'd3, 1'b1);
      // after reset and wrap: reset config still in force
      add_p(8, 100, 100, 12'h888); add_p(8, 100, 250, 12'h888); add_p(8, 10, 78, 12'hfff);

      repeat (3) @(posedge pclk);
      #1;
      chk("reset rgb", 32'(rgb_out), 32'd0);
      chk("reset timing", 32'({vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out}), 32'd0);
      chk("reset frame_cnt", 32'(frame_cnt), 32'd0);
      chk("reset cfg_ready", 32'(cfg_ready), 32'd1);
      rst = 1'b0;

      for (int t = 0; t < 5; t++) run_frame(t);
      repeat (11) fast_frame();
      chk("frame_cnt before blink frame", 32'(frame_cnt), 32'd16);
      run_frame(5);
      run_frame(6);

      for (int h = 0; h <= 20; h++) drive_px(7, 200, h, 1'b0);
      @(posedge pclk); #2;
      rst = 1'b1;
      #1;
      chk("midrst rgb", 32'(rgb_out), 32'd0);
      chk("midrst timing", 32'({vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out}), 32'd0);
      chk("midrst frame_cnt", 32'(frame_cnt), 32'd0);
      chk("midrst cfg_ready", 32'(cfg_ready), 32'd1);
      @(posedge pclk); @(posedge pclk); #1;
      rst = 1'b0;
      fc_model = 8'd0;
      vb_prev_drv = 1'b0;

      repeat (255) fast_frame();
      chk("frame_cnt 255", 32'(frame_cnt), 32'd255);
      fast_frame();
      chk("frame_cnt wrap", 32'(frame_cnt), 32'd0);
      run_frame(8);

      repeat (5) @(posedge pclk);
      #1;
      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
